// File: rtl/instr_encoder_pkg.sv
// instr_encoder_pkg: shared kinds, ALU-control codes, opcodes and funct fields for RV32I encoding
package instr_encoder_pkg;
  typedef enum logic [2:0] {K_LW, K_SW, K_RTYPE, K_BEQ, K_ITYPE, K_JAL} kind_t;
  typedef enum logic [1:0] {S_IDLE, S_LOAD, S_DONE} state_t;
  localparam logic [2:0] ALU_ADD = 3'b000;
  localparam logic [2:0] ALU_SUB = 3'b001;
  localparam logic [2:0] ALU_AND = 3'b010;
  localparam logic [2:0] ALU_OR  = 3'b011;
  localparam logic [2:0] ALU_SLT = 3'b101;
  localparam logic [6:0] OP_LW  = 7'b0000011;
  localparam logic [6:0] OP_SW  = 7'b0100011;
  localparam logic [6:0] OP_R   = 7'b0110011;
  localparam logic [6:0] OP_BEQ = 7'b1100011;
  localparam logic [6:0] OP_I   = 7'b0010011;
  localparam logic [6:0] OP_JAL = 7'b1101111;
  localparam logic [2:0] F3_ADD = 3'b000;
  localparam logic [2:0] F3_SLT = 3'b010;
  localparam logic [2:0] F3_OR  = 3'b110;
  localparam logic [2:0] F3_AND = 3'b111;
  localparam logic [2:0] F3_W   = 3'b010;
  localparam logic [2:0] F3_BEQ = 3'b000;
  localparam logic [6:0] F7_SUB = 7'b0100000;
  localparam logic [6:0] F7_0   = 7'b0000000;
  function automatic logic [2:0] alu_f3(input logic [2:0] alu);
    return alu == ALU_SLT ? F3_SLT : alu == ALU_OR ? F3_OR : alu == ALU_AND ? F3_AND : F3_ADD;
  endfunction
  function automatic logic alu_legal(input logic [2:0] alu);
    return alu == ALU_ADD || alu == ALU_SUB || alu == ALU_AND || alu == ALU_OR || alu == ALU_SLT;
  endfunction
endpackage

// File: rtl/instr_pack.sv
// instr_pack: combinational encode of one descriptor into an RV32I word plus legal flag
// Immediate range checks are enforced only when ENC_RANGE_CHECK_EN is defined.
module instr_pack
  import instr_encoder_pkg::*;
(
  input  logic [2:0]  kind,
  input  logic [2:0]  alu,
  input  logic [4:0]  rd,
  input  logic [4:0]  rs1,
  input  logic [4:0]  rs2,
  input  logic [31:0] imm,
  output logic [31:0] word,
  output logic        legal
);
  logic i_ok, b_ok, j_ok;
`ifdef ENC_RANGE_CHECK_EN
  assign i_ok = $signed(imm) >= -2048 && $signed(imm) <= 2047;
  assign b_ok = $signed(imm) >= -4096 && $signed(imm) <= 4094 && !imm[0];
  assign j_ok = $signed(imm) >= -1048576 && $signed(imm) <= 1048574 && !imm[0];
`else
  logic unused_imm;
  assign i_ok = 1'b1;
  assign b_ok = 1'b1;
  assign j_ok = 1'b1;
  assign unused_imm = ^imm[31:21];
`endif
  logic [2:0] f3;
  logic       alu_ok;
  assign f3 = alu_f3(alu);
  assign alu_ok = alu_legal(alu);
  always_comb begin
    word = 32'h0;
    legal = 1'b0;
    case (kind)
      K_LW: begin
        word = {imm[11:0], rs1, F3_W, rd, OP_LW};
        legal = i_ok;
      end
      K_SW: begin
        word = {imm[11:5], rs2, rs1, F3_W, imm[4:0], OP_SW};
        legal = i_ok;
      end
      K_RTYPE: begin
        word = {alu == ALU_SUB ? F7_SUB : F7_0, rs2, rs1, f3, rd, OP_R};
        legal = alu_ok;
      end
      K_BEQ: begin
        word = {imm[12], imm[10:5], rs2, rs1, F3_BEQ, imm[4:1], imm[11], OP_BEQ};
        legal = b_ok;
      end
      K_ITYPE: begin
        word = {imm[11:0], rs1, f3, rd, OP_I};
        legal = alu_ok && alu != ALU_SUB && i_ok;
      end
      K_JAL: begin
        word = {imm[20], imm[10:1], imm[11], imm[19:12], rd, OP_JAL};
        legal = j_ok;
      end
      default: ;
    endcase
  end
endmodule

// File: rtl/instr_encoder.sv
// instr_encoder: streams descriptors into instruction memory and holds the core in reset until loaded
// Optional immediate range checking in instr_pack via ENC_RANGE_CHECK_EN.
module instr_encoder
  import instr_encoder_pkg::*;
#(
  parameter logic [31:0] BASE_ADDR = 32'h0,
  parameter int          DEPTH = 64
) (
  input  logic        clk,
  input  logic        reset,
  input  logic        start,
  input  logic        in_valid,
  output logic        in_ready,
  input  logic [2:0]  in_kind,
  input  logic [2:0]  in_alu,
  input  logic [4:0]  in_rd,
  input  logic [4:0]  in_rs1,
  input  logic [4:0]  in_rs2,
  input  logic [31:0] in_imm,
  input  logic        in_last,
  output logic        imem_we,
  output logic [31:0] imem_addr,
  output logic [31:0] imem_wdata,
  output logic        core_reset,
  output logic        done,
  output logic        err,
  output logic [7:0]  err_count
);
  localparam int CW = $clog2(DEPTH + 1);
  state_t        state, state_nxt;
  logic [31:0]   ptr, word;
  logic [CW-1:0] wr_count;
  logic          last_pending, full, legal, acc, we_r;
  instr_pack u_pack (
    .kind(in_kind),
    .alu(in_alu),
    .rd(in_rd),
    .rs1(in_rs1),
    .rs2(in_rs2),
    .imm(in_imm),
    .word(word),
    .legal(legal)
  );
  assign full = wr_count == CW'(DEPTH);
  assign acc = in_valid & in_ready & ~start;
  // a write already registered is suppressed while reset is held
  assign imem_we = we_r & ~reset;
  always_ff @(posedge clk)
    state <= reset ? S_IDLE : state_nxt;
  always_comb
    state_nxt = start ? S_LOAD : (state == S_LOAD && (last_pending || full)) ? S_DONE : state;
  always_comb begin
    in_ready = state == S_LOAD && !last_pending && !full;
    done = state == S_DONE;
    core_reset = state != S_DONE;
  end
  always_ff @(posedge clk) begin
    if (reset) begin
      ptr <= BASE_ADDR;
      wr_count <= '0;
      last_pending <= 1'b0;
      we_r <= 1'b0;
      imem_addr <= BASE_ADDR;
      imem_wdata <= 32'h0;
      err <= 1'b0;
      err_count <= 8'h0;
    end else if (start) begin
      ptr <= BASE_ADDR;
      wr_count <= '0;
      last_pending <= 1'b0;
      we_r <= 1'b0;
      err <= 1'b0;
      err_count <= 8'h0;
    end else begin
      we_r <= acc & legal;
      if (acc & legal) begin
        imem_addr <= ptr;
        imem_wdata <= word;
        ptr <= ptr + 32'd4;
        wr_count <= wr_count + CW'(1);
      end
      if (acc & in_last) last_pending <= 1'b1;
      if (acc & ~legal) begin
        err <= 1'b1;
        err_count <= err_count + {7'd0, ~&err_count};
      end
      if (state == S_LOAD && full && !last_pending) err <= 1'b1;
    end
  end
endmodule
